// File: rtl/encoder_scheduler_if.sv
// Register bus between a host and encoder_scheduler: one access per cycle with sel high,
// acknowledged one cycle later by a single-cycle ready pulse.
interface encoder_scheduler_if;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ready;

  modport master (output sel, we, addr, din, input  dout, ready);
  modport slave  (input  sel, we, addr, din, output dout, ready);
endinterface

// File: rtl/encoder_scheduler.sv
// Four-channel quadrature encoder counter; one shared decoder visits the channels in turn on each prescaler tick.
// Optional interrupt/status logic is built when ENCODER_SCHED_IRQ_EN is defined.
module encoder_scheduler #(
  parameter int DIV_WIDTH = 8,
  parameter int N_CH      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] a,
  input  logic [N_CH-1:0] b,
  encoder_scheduler_if.slave bus
`ifdef ENCODER_SCHED_IRQ_EN
  ,
  output logic            irq
`endif
);

  typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE, NEXT} state_t;
  localparam logic [1:0] LAST_CH = 2'(N_CH - 1);

  state_t                    state, state_nxt;
  logic [1:0]                ch, ch_nxt;
  logic [DIV_WIDTH-1:0]      presc;
  logic                      tick;
  logic                      sa, sb;
  logic [N_CH-1:0]           pa, pb, primed;
  logic [N_CH-1:0][15:0]     value;
  logic [15:0]               cur, upd_val;
  logic                      cnt, dir;
  logic                      wr_ch;
  logic [15:0]               rd_data, status_rd;
  logic [15:0]               dout_q;
  logic                      ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + 1'b1;
  end

  assign tick = &presc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end
  end

  // Ticks outside IDLE fall through the default hold and are simply lost.
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    case (state)
      IDLE:   if (tick) begin
                state_nxt = SAMPLE;
                ch_nxt    = '0;
              end
      SAMPLE: state_nxt = UPDATE;
      UPDATE: state_nxt = NEXT;
      NEXT:   if (ch != LAST_CH) begin
                state_nxt = SAMPLE;
                ch_nxt    = ch + 1'b1;
              end else begin
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  assign cur = value[ch];
  assign cnt = sa ^ pa[ch] ^ sb ^ pb[ch];
  assign dir = sa ^ pb[ch];

  always_comb begin
    upd_val = cur;
    if (state == UPDATE && primed[ch] && cnt) begin
      if (dir && cur != 16'hFFFF)      upd_val = cur + 16'd1;
      else if (!dir && cur != 16'h0000) upd_val = cur - 16'd1;
    end
  end

  assign wr_ch = bus.sel && bus.we && !bus.addr[2];

  // The bus write is assigned last so it overrides a scan update of the same channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value  <= '0;
      pa     <= '0;
      pb     <= '0;
      primed <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
    end else begin
      if (state == SAMPLE) begin
        sa <= a[ch];
        sb <= b[ch];
      end
      if (state == UPDATE) begin
        pa[ch]     <= sa;
        pb[ch]     <= sb;
        primed[ch] <= 1'b1;
        value[ch]  <= upd_val;
      end
      if (wr_ch) value[bus.addr[1:0]] <= bus.din;
    end
  end

`ifdef ENCODER_SCHED_IRQ_EN
  logic [N_CH-1:0] status, set_mask, clr_mask;
  logic            scan_hit;

  assign scan_hit = (upd_val != cur) && !(wr_ch && bus.addr[1:0] == ch);
  assign set_mask = scan_hit ? (N_CH'(1) << ch) : '0;
  assign clr_mask = (bus.sel && bus.we && bus.addr == 3'd4) ? bus.din[N_CH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= (status & ~clr_mask) | set_mask;
      irq    <= |status;
    end
  end

  assign status_rd = {{(16-N_CH){1'b0}}, status};
`else
  assign status_rd = 16'h0000;
`endif

  always_comb begin
    rd_data = '0;
    if (!bus.addr[2])          rd_data = value[bus.addr[1:0]];
    else if (bus.addr == 3'd4) rd_data = status_rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= bus.sel;
      if (bus.sel && !bus.we) dout_q <= rd_data;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_encoder_scheduler.sv
// Randomised and directed checks of encoder_scheduler against a phase-position reference model.
`timescale 1ns/1ps
module tb_encoder_scheduler;
  localparam int DW  = 4;
  localparam int PER = 1 << DW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0, b = '0;

  encoder_scheduler_if bus();
`ifdef ENCODER_SCHED_IRQ_EN
  logic irq;
`endif

  encoder_scheduler #(.DIV_WIDTH(DW), .N_CH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .bus  (bus)
`ifdef ENCODER_SCHED_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each channel's phase pair is a position on the 4-step cycle 00,10,11,01;
  // a move of +1 counts up, -1 counts down, +2 is ambiguous and ignored.
  logic [15:0] m_val [4];
  logic [1:0]  m_prev[4];
  logic [3:0]  m_primed, m_status, m_clr;
  logic [1:0]  m_samp;
  logic [15:0] m_dout, m_nv;
  logic        m_ready, m_irq, m_hit;
  int          m_phase, m_c, m_d;
  bit          m_run;

  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] status_view();
`ifdef ENCODER_SCHED_IRQ_EN
    return {12'h000, m_status};
`else
    return 16'h0000;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i]  = '0;
        m_prev[i] = '0;
      end
      m_primed = '0; m_status = '0; m_samp = '0;
      m_dout = '0; m_ready = 1'b0; m_irq = 1'b0;
      m_phase = 0; m_run = 1'b0;
    end else begin
      m_irq   = |m_status;
      m_ready = bus.sel;
      if (bus.sel && !bus.we)
        m_dout = (bus.addr < 4) ? m_val[bus.addr[1:0]] : (bus.addr == 4) ? status_view() : 16'h0;
      m_hit = 1'b0;
      m_c   = m_phase / 3;
      // A scan spends three cycles per channel: sample, then commit on the next.
      if (m_run && m_phase < 12) begin
        if (m_phase % 3 == 0) m_samp = {a[m_c], b[m_c]};
        else if (m_phase % 3 == 1) begin
          m_nv = m_val[m_c];
          if (m_primed[m_c]) begin
            m_d = (gpos(m_samp) - gpos(m_prev[m_c]) + 4) % 4;
            if (m_d == 1 && m_nv != 16'hFFFF) m_nv = m_nv + 1;
            if (m_d == 3 && m_nv != 16'h0000) m_nv = m_nv - 1;
          end
          m_hit         = (m_nv != m_val[m_c]);
          m_val[m_c]    = m_nv;
          m_prev[m_c]   = m_samp;
          m_primed[m_c] = 1'b1;
        end
      end
      m_clr = '0;
      if (bus.sel && bus.we) begin
        if (bus.addr < 4) begin
          m_val[bus.addr[1:0]] = bus.din;
          if (int'(bus.addr[1:0]) == m_c) m_hit = 1'b0;
        end else if (bus.addr == 4) m_clr = bus.din[3:0];
      end
      m_status = (m_status & ~m_clr) | (m_hit ? (4'b1 << m_c) : 4'b0);
      if (m_phase == PER - 1) m_run = 1'b1;
      m_phase = (m_phase + 1) % PER;
    end
  end

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon ready", 16'(bus.ready), 16'(m_ready));
      chk("mon dout", bus.dout, m_dout);
`ifdef ENCODER_SCHED_IRQ_EN
      chk("mon irq", 16'(irq), 16'(m_irq));
`endif
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic idle_bus();
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
  endtask

  task automatic rd(input logic [2:0] ad, input logic [15:0] exp, input string tag);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = ad;
    @(negedge clk);
    bus.sel = 1'b0;
    chk({tag, " ready"}, 16'(bus.ready), 16'd1);
    chk(tag, bus.dout, exp);
  endtask

  task automatic wr(input logic [2:0] ad, input logic [15:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = ad; bus.din = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_run && m_phase == p) && n < 4 * PER);
    if (n >= 4 * PER) chk("wait_phase timeout", 16'd0, 16'd1);
  endtask

  task automatic step(input int c, input logic [1:0] ab);
    wait_phase(13);
    a[c] = ab[1];
    b[c] = ab[0];
    wait_phase(12);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", 16'(bus.ready), 16'd0);
    chk("reset dout", bus.dout, 16'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) rd(3'(i), 16'd0, "reset value");

    // Forward through one full electrical cycle on ch0.
    step(0, 2'b10); step(0, 2'b11); step(0, 2'b01); step(0, 2'b00);
    rd(3'd0, 16'd4, "fwd ch0");
    for (int i = 1; i < 4; i++) rd(3'(i), 16'd0, "fwd other ch");

    // Saturation at both ends on ch2.
    wr(3'd2, 16'hFFFE);
    step(2, 2'b10); step(2, 2'b11); step(2, 2'b01);
    rd(3'd2, 16'hFFFF, "sat high");
    wr(3'd2, 16'h0001);
    step(2, 2'b11); step(2, 2'b10);
    rd(3'd2, 16'h0000, "sat low");

    wr(3'd5, 16'hABCD);
    rd(3'd5, 16'h0000, "addr5 read");
    rd(3'd7, 16'h0000, "addr7 read");
    wr(3'd4, 16'h000F);

    // Bus write lands in the UPDATE cycle of ch1 together with a forward step.
    wait_phase(13);
    a[1] = 1'b1; b[1] = 1'b0;
    wait_phase(4);
    wr(3'd1, 16'h1234);
    wait_phase(12);
    rd(3'd1, 16'h1234, "write wins");
    rd(3'd4, 16'h0000, "write wins status");
    wait_phase(12);
    rd(3'd1, 16'h1234, "write wins hold");

    // Both phases toggle together: ambiguous, no count.
    step(3, 2'b11);
    rd(3'd3, 16'h0000, "double toggle");
    rd(3'd4, 16'h0000, "double toggle status");

`ifdef ENCODER_SCHED_IRQ_EN
    step(0, 2'b10);
    rd(3'd0, 16'd5, "irq step value");
    rd(3'd4, 16'h0001, "irq status set");
    chk("irq set", 16'(irq), 16'd1);
    wr(3'd4, 16'h0001);
    @(negedge clk);
    chk("irq clear", 16'(irq), 16'd0);
    rd(3'd4, 16'h0000, "irq status clear");
`endif

    // Reset during UPDATE of ch2 with a read presented in the same cycle.
    wait_phase(13);
    a = 4'hF; b = 4'hF;
    wait_phase(7);
    rst_n = 1'b0;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bus();
    chk("mid-scan reset ready", 16'(bus.ready), 16'd0);
    chk("mid-scan reset dout", bus.dout, 16'd0);
    for (int i = 0; i < 4; i++) rd(3'(i), 16'd0, "after reset");
    wait_phase(12);
    wait_phase(12);
    for (int i = 0; i < 4; i++) rd(3'(i), 16'd0, "prime only");
    rd(3'd4, 16'h0000, "prime only status");

    // Random traffic: phase changes at arbitrary times, mixed reads and writes.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        a[$urandom_range(0, 3)] = 1'($urandom);
        b[$urandom_range(0, 3)] = 1'($urandom);
      end
      bus.sel  = ($urandom_range(0, 2) == 0);
      bus.we   = 1'($urandom);
      bus.addr = 3'($urandom);
      case ($urandom_range(0, 4))
        0:       bus.din = 16'h0000;
        1:       bus.din = 16'hFFFF;
        2:       bus.din = 16'hFFFE;
        3:       bus.din = 16'h0001;
        default: bus.din = 16'($urandom);
      endcase
    end
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    for (int i = 0; i < 4; i++) rd(3'(i), m_val[i], "random final");
    rd(3'd4, status_view(), "random final status");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/encoder_scheduler.md
ENCODER_SCHEDULER -- requirements
Module: encoder_scheduler

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, width of the scan-tick prescaler.
REQ-002 SHALL have parameter N_CH, fixed 4, the number of encoder channels.
REQ-003 SHALL have port clk, input, 1, the system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port a, input, 4, quadrature phase A per channel, already debounced and synchronised.
REQ-006 SHALL have port b, input, 4, quadrature phase B per channel, already debounced and synchronised.
REQ-007 SHALL have port sel, input, 1, bus access strobe; each cycle with sel=1 is a separate access.
REQ-008 SHALL have port we, input, 1, 1=write, 0=read; qualified by sel.
REQ-009 SHALL have port addr, input, 3: 0-3 select channel value registers; 4 selects the status register.
REQ-010 SHALL have port din, input, 16, write data.
REQ-011 SHALL have port dout, output, 16, registered read data.
REQ-012 SHALL have port ready, output, 1, one-cycle pulse acknowledging an access.

Function
REQ-013 Prescaler SHALL count freely; tick SHALL assert for one cycle when the prescaler wraps from all-ones to 0.
REQ-014 The single shared decode/update datapath SHALL be sequenced by an FSM with states IDLE, SAMPLE, UPDATE and NEXT.
REQ-015 FSM transitions: IDLE->SAMPLE on tick with ch=0; SAMPLE->UPDATE; UPDATE->NEXT; NEXT->SAMPLE with ch+1 if ch<3, else NEXT->IDLE.
REQ-016 A full scan SHALL take 12 cycles.
REQ-017 A tick occurring while the FSM is not in IDLE SHALL be ignored, not queued.
REQ-018 SAMPLE SHALL latch {a[ch],b[ch]}; UPDATE SHALL compute cnt = a^pa^b^pb and dir = a^pb, where pa/pb are that channel's stored previous phases.
REQ-019 UPDATE SHALL then store the sampled phases as the channel's new pa/pb.
REQ-020 On cnt=1, dir=1: value[ch] SHALL increment by 1, saturating at 0xFFFF.
REQ-021 On cnt=1, dir=0: value[ch] SHALL decrement by 1, saturating at 0x0000.
REQ-022 When both phases change between samples, cnt evaluates to 0; this SHALL produce no count.
REQ-023 The first scan after reset SHALL only prime pa/pb (primed flag clear) and SHALL produce no counts.
REQ-024 Read access: dout SHALL present value[addr] (or status for addr=4) and ready SHALL pulse, both one cycle after sel.
REQ-025 Reads of addr 5-7 SHALL return 0 and SHALL still pulse ready.
REQ-026 Write access: value[addr] <= din in the cycle after sel, with ready pulsing in that same cycle.
REQ-027 A write to the channel in UPDATE in the same cycle SHALL win; that scan update SHALL be dropped, but pa/pb SHALL still update.
REQ-028 Writes to addr 4-7 SHALL have no effect on values.
REQ-029 dout SHALL hold its last value when no read is in progress.

Reset
REQ-030 With rst_n=0 at a clock edge, the following SHALL clear: value[0..3]=0, pa/pb=0, primed=0, prescaler=0, FSM=IDLE, ch=0, dout=0, ready=0, status=0, irq=0.
REQ-031 Reset asserted mid-scan SHALL abort the scan with no partial update.
REQ-032 Reset asserted mid-scan SHALL NOT emit a ready pulse for an access presented in the reset cycle.

Configuration
REQ-033 Macro ENCODER_SCHED_IRQ_EN SHALL control the interrupt feature.
REQ-034 With ENCODER_SCHED_IRQ_EN defined: output port irq (1 bit) SHALL exist.
REQ-035 With ENCODER_SCHED_IRQ_EN defined: status[3:0] SHALL set bit ch when a scan changes value[ch].
REQ-036 With ENCODER_SCHED_IRQ_EN defined: a write to addr 4 SHALL clear the status bits where din is 1 (write-1-to-clear).
REQ-037 With ENCODER_SCHED_IRQ_EN defined: irq SHALL be a registered OR of status.
REQ-038 With ENCODER_SCHED_IRQ_EN defined: a same-cycle set and clear of a status bit SHALL leave it set.
REQ-039 Without ENCODER_SCHED_IRQ_EN: the irq port SHALL be absent, status logic SHALL not exist, and addr 4 SHALL read 0.

Verification
REQ-040 Bench SHALL cover, with DIV_WIDTH=4: after reset hold a=b=0, then step ch0 through 00->10->11->01->00, one step per scan -> value[0] reads 4 and ch1-3 read 0.
REQ-041 Bench SHALL cover: write 0xFFFE to ch2, then 3 forward steps -> reads 0xFFFF; write 1, then 2 reverse steps -> reads 0.
REQ-042 Bench SHALL cover: a forward step on ch1 with a write of 0x1234 to ch1 in the same cycle as UPDATE -> reads 0x1234, and the next scan without a step leaves it unchanged.
REQ-043 Bench SHALL cover: toggle a and b together on ch3 -> value[3] unchanged and no status bit set.
REQ-044 Bench SHALL cover: assert rst_n=0 during UPDATE of ch2 -> all values 0, and the next scan after reset produces no count even with inputs at 11.
REQ-045 Bench SHALL cover, with the IRQ macro defined: a step on ch0 -> status=0x1 and irq=1; write 0x1 to addr 4 -> status=0, irq=0 one cycle later.
